dmem_responder: RTL and testbench

- Multi-cycle data-memory responder. It sits at the memory end of the processor's data-side request interface (enable, wr, addr, data_in, data_out).
- It replaces the zero-latency data store and drives a real stall back to the core, so the hazard logic's dcache stall input is exercised.
- A request is latched, serviced after a programmable latency, and completed with a one-cycle done pulse.
- Misaligned word accesses are rejected with an error pulse.

---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches a request, stalls the core for LATENCY cycles,
// then pulses done (or err for a rejected request). Define DMEM_BYTE_EN for byte-enable stores.
module dmem_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        counter;
  logic              lat_wr;
  logic [IDX_W-1:0]  lat_idx;
  logic [31:0]       lat_data;
  logic [3:0]        lat_be;
  logic [31:0]       mem [MEM_WORDS];

  logic              accept, bad, good, complete;
  logic [3:0]        req_be;
  logic              acc_wr;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       acc_data;
  logic [3:0]        acc_be;
  logic              unused_addr;

  assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

`ifdef DMEM_BYTE_EN
  // Only single bytes, aligned halves and the full word are legal footprints.
  assign req_be = be;
  always_comb begin
    bad = 1'b1;
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: bad = 1'b0;
      default:                   bad = 1'b1;
    endcase
  end
`else
  assign req_be = 4'hF;
  assign bad    = (addr[1:0] != 2'b00);
`endif

  assign accept = enable && (state != BUSY);
  assign good   = accept && !bad;
  assign stall  = (state == BUSY) || ((state == IDLE) && good);
  assign done   = (state == RESP);

  // With LATENCY==1 the access happens on the accepting edge, straight from the inputs.
  assign complete = ((state == BUSY) && (counter == 4'd1)) || ((LATENCY == 1) && good);
  assign acc_wr   = (state == BUSY) ? lat_wr   : wr;
  assign acc_idx  = (state == BUSY) ? lat_idx  : addr[IDX_W+1:2];
  assign acc_data = (state == BUSY) ? lat_data : data_in;
  assign acc_be   = (state == BUSY) ? lat_be   : req_be;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RESP: begin
        if (good) state_next = (LATENCY == 1) ? RESP : BUSY;
        else      state_next = IDLE;
      end
      BUSY:    if (counter == 4'd1) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      counter  <= 4'd0;
      lat_wr   <= 1'b0;
      lat_idx  <= '0;
      lat_data <= 32'd0;
      lat_be   <= 4'd0;
      data_out <= 32'd0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      err   <= accept && bad;
      if (good) begin
        lat_wr   <= wr;
        lat_idx  <= addr[IDX_W+1:2];
        lat_data <= data_in;
        lat_be   <= req_be;
        counter  <= 4'(LATENCY - 1);
      end else if (state == BUSY) begin
        counter <= counter - 4'd1;
      end
      if (complete && !acc_wr) data_out <= mem[acc_idx];
    end
  end

  // Backing array is not reset; a reset during BUSY leaves state IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (complete && acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][b*8 +: 8] <= acc_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=4, MEM_WORDS=1024);
// byte-enable checks run when DMEM_BYTE_EN is defined.
module tb_dmem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data_in = 32'd0;
`ifdef DMEM_BYTE_EN
  logic [3:0]  be = 4'hF;
`endif
  logic [31:0] data_out;
  logic        stall, done, err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.LATENCY(LAT), .MEM_WORDS(1024), .IDX_W(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
`ifdef DMEM_BYTE_EN
    .be(be),
`endif
    .data_out(data_out), .stall(stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic w, input logic [31:0] a, input logic [31:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request from IDLE, held until done, then released; ends back in IDLE.
  task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
    int n;
    n = 0;
    applyStimulus(1'b1, w, a, d);
    checkOutput({tag, "_stall_accept"}, 32'(stall), 32'd1);
    while (done !== 1'b1 && n < 20) begin
      nextCycle;
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(LAT));
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput({tag, "_stall_resp"}, 32'(stall), 32'd0);
    nextCycle;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_data_out", data_out, 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    nextCycle;
    nextCycle;
    rst = 1'b1;

    transact(1'b1, 32'h40, 32'h0BADF00D, "st40");

    // Store then load at 0x100 with exact cycle-by-cycle stall/done profile.
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) nextCycle;
      if (c == 0)      applyStimulus(1'b1, 1'b1, 32'h100, 32'h12345678);
      else if (c == 4) applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
      else if (c == 8) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      else             #1;
      checkOutput($sformatf("raw_stall_c%0d", c), 32'(stall), ((c % 4 != 0) || c == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("raw_done_c%0d", c), 32'(done), (c == 4 || c == 8) ? 32'd1 : 32'd0);
      if (c == 8) checkOutput("raw_data", data_out, 32'h12345678);
    end
    nextCycle;
    checkOutput("raw_done_after", 32'(done), 32'd0);
    checkOutput("raw_data_held", data_out, 32'h12345678);

    // Rejected requests: misaligned load, then misaligned store.
`ifdef DMEM_BYTE_EN
    be = 4'b0101;
`endif
    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0);
    checkOutput("mis_ld_stall", 32'(stall), 32'd0);
    checkOutput("mis_ld_err_early", 32'(err), 32'd0);
    nextCycle;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("mis_ld_err", 32'(err), 32'd1);
    checkOutput("mis_ld_stall2", 32'(stall), 32'd0);
    checkOutput("mis_ld_done", 32'(done), 32'd0);
    checkOutput("mis_ld_data", data_out, 32'h12345678);
    nextCycle;
    checkOutput("mis_ld_err_pulse", 32'(err), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h101, 32'hFFFFFFFF);
    checkOutput("mis_st_stall", 32'(stall), 32'd0);
    nextCycle;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("mis_st_err", 32'(err), 32'd1);
`ifdef DMEM_BYTE_EN
    be = 4'hF;
`endif
    nextCycle;
    transact(1'b0, 32'h100, 32'h0, "ld100");
    checkOutput("mis_st_no_write", data_out, 32'h12345678);

    // Aliasing modulo 4 KiB and the last word.
    transact(1'b1, 32'h0000_1000, 32'hA5A5A5A5, "st1000");
    transact(1'b0, 32'h0, 32'h0, "ld0");
    checkOutput("alias_data", data_out, 32'hA5A5A5A5);
    transact(1'b1, 32'hFFC, 32'hCAFEF00D, "stFFC");
    transact(1'b0, 32'hFFC, 32'h0, "ldFFC");
    checkOutput("last_word", data_out, 32'hCAFEF00D);
    transact(1'b0, 32'h0, 32'h0, "ld0b");
    checkOutput("word0_intact", data_out, 32'hA5A5A5A5);

    // Back-to-back loads, with junk stores driven during BUSY.
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) nextCycle;
      if (c == 0)       applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
      else if (c == 4)  applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
      else if (c == 8)  applyStimulus(1'b1, 1'b0, 32'hFFC, 32'h0);
      else if (c == 12) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      else              applyStimulus(1'b1, 1'b1, 32'h40, 32'hFFFFFFFF);
      checkOutput($sformatf("b2b_stall_c%0d", c), 32'(stall), ((c % 4 != 0) || c == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b_done_c%0d", c), 32'(done), (c != 0 && c % 4 == 0) ? 32'd1 : 32'd0);
      if (c == 4)  checkOutput("b2b_data1", data_out, 32'h12345678);
      if (c == 8)  checkOutput("b2b_data2", data_out, 32'hA5A5A5A5);
      if (c == 12) checkOutput("b2b_data3", data_out, 32'hCAFEF00D);
    end
    nextCycle;

    // Reset in the middle of a store aborts it.
    applyStimulus(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    nextCycle;
    nextCycle;
    #2;
    rst    = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("abort_stall", 32'(stall), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    checkOutput("abort_data_out", data_out, 32'd0);
    nextCycle;
    rst = 1'b1;
    nextCycle;
    transact(1'b0, 32'h40, 32'h0, "ld40");
    checkOutput("abort_no_write", data_out, 32'h0BADF00D);

`ifdef DMEM_BYTE_EN
    be = 4'hF;
    transact(1'b1, 32'h20, 32'h11223344, "be_init");
    be = 4'b0010;
    transact(1'b1, 32'h20, 32'hAABBCCDD, "be_lane1");
    be = 4'hF;
    transact(1'b0, 32'h20, 32'h0, "be_ld1");
    checkOutput("be_merge", data_out, 32'h1122CC44);
    be = 4'b0101;
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hAABBCCDD);
    checkOutput("be_bad_stall", 32'(stall), 32'd0);
    nextCycle;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("be_bad_err", 32'(err), 32'd1);
    be = 4'hF;
    nextCycle;
    transact(1'b0, 32'h20, 32'h0, "be_ld2");
    checkOutput("be_bad_unchanged", data_out, 32'h1122CC44);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
